// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: ROM address/data, branch redirect, and the decode-side
// valid/ready handshake with the sticky fault flag.
interface instruction_fetch_if;
  logic [15:0] imem_addr;
  logic [15:0] imem_instr;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        id_ready;
  logic        fault;

  modport master (
    output imem_addr, if_valid, if_instr, if_pc, fault,
    input  imem_instr, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_addr, if_valid, if_instr, if_pc, fault,
    output imem_instr, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, captures ROM words into a small in-order queue and
// presents the queue head to decode; supports redirect/flush and a sticky fault.
module instruction_fetch #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int unsigned PC_STEP    = 4,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned MEM_SIZE   = 1024
) (
  input  logic clk,
  input  logic reset,
  instruction_fetch_if.master bus
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {RUN, FULL, FAULT} state_t;

  state_t      state, state_n;
  logic [15:0] pc, pc_n;
  logic [CW-1:0] count, count_n, base;
  logic [15:0] q_pc    [FIFO_DEPTH];
  logic [15:0] q_ins   [FIFO_DEPTH];
  logic [15:0] q_pc_n  [FIFO_DEPTH];
  logic [15:0] q_ins_n [FIFO_DEPTH];
  logic        pop, push, pc_legal, rd_legal;

  function automatic logic legal(input logic [15:0] a);
    return (a[1:0] == 2'b00) && ((32'(a) + 32'd3) < MEM_SIZE);
  endfunction

  assign pc_legal      = legal(pc);
  assign rd_legal      = legal(bus.redirect_pc);
  assign bus.imem_addr = pc;
  assign bus.if_valid  = (count != '0);
  assign bus.if_pc     = q_pc[0];
  assign bus.if_instr  = q_ins[0];
  assign bus.fault     = (state == FAULT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      pc    <= RESET_PC;
      count <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        q_pc[i]  <= '0;
        q_ins[i] <= '0;
      end
    end else begin
      state <= state_n;
      pc    <= pc_n;
      count <= count_n;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        q_pc[i]  <= q_pc_n[i];
        q_ins[i] <= q_ins_n[i];
      end
    end
  end

  // Queue is a shift register with entry 0 as the head, so the decode-facing
  // outputs come straight from flops and hold while decode stalls.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    count_n = count;
    base    = count;
    q_pc_n  = q_pc;
    q_ins_n = q_ins;
    pop     = (count != '0) && bus.id_ready;
    push    = !bus.redirect_valid && (state != FAULT) && pc_legal &&
              ((count < CW'(FIFO_DEPTH)) || pop);

    if (bus.redirect_valid) begin
      count_n = '0;
      if (rd_legal) begin
        pc_n    = bus.redirect_pc;
        state_n = RUN;
      end else begin
        state_n = FAULT;
      end
    end else begin
      if (pop) begin
        for (int unsigned i = 0; i + 1 < FIFO_DEPTH; i++) begin
          q_pc_n[i]  = q_pc[i+1];
          q_ins_n[i] = q_ins[i+1];
        end
        base = count - CW'(1);
      end
      if (push) begin
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
          if (CW'(i) == base) begin
            q_pc_n[i]  = pc;
            q_ins_n[i] = bus.imem_instr;
          end
        end
        pc_n = pc + 16'(PC_STEP);
      end
      count_n = base + CW'(push);

      if ((state == FAULT) || !pc_legal)
        state_n = FAULT;
      else if (count_n == CW'(FIFO_DEPTH))
        state_n = FULL;
      else
        state_n = RUN;
    end
  end

endmodule
